// File: rtl/zx_pkg.sv
// Shared constants for the ZX Spectrum ULA I/O port block.
//   KEY_ROWS / KEY_COLS : keyboard matrix geometry (8 half-rows of 5 keys)
//   KEY_*               : flat key indices, index = row*KEY_COLS + bit
//   ULA_*_BIT           : bit positions on the ULA port data bus
package zx_pkg;

  localparam int KEY_ROWS = 8;
  localparam int KEY_COLS = 5;
  localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

  localparam int KEY_CAPS  = 0;
  localparam int KEY_ENTER = 30;
  localparam int KEY_SPACE = 35;

  localparam int ULA_MIC_BIT = 3;
  localparam int ULA_SPK_BIT = 4;
  localparam int ULA_EAR_BIT = 6;

endpackage

// File: rtl/zx_key_debounce.sv
// Key matrix synchroniser and debouncer.
//   clk, reset (async, active-low)
//   raw   [WIDTH]  : asynchronous active-low key inputs
//   state [WIDTH]  : debounced key state, active-low
// Every input passes a 2-FF synchroniser. A shared counter produces a tick
// every DB_CYCLES clocks; a bit is only accepted when two consecutive tick
// samples agree, so pulses shorter than one tick interval never get through.
module zx_key_debounce #(
  parameter int WIDTH     = 40,
  parameter int DB_CYCLES = 35_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] state
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] last_sample;
  logic [WIDTH-1:0] agree;
  logic [CW-1:0]    cnt;
  logic             tick;

  assign tick  = (cnt == CW'(DB_CYCLES - 1));
  assign agree = ~(sync2 ^ last_sample);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1       <= '1;
      sync2       <= '1;
      last_sample <= '1;
      state       <= '1;
      cnt         <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        cnt         <= '0;
        last_sample <= sync2;
        // take the synchronised value only where it matches the previous sample
        state       <= (state & ~agree) | (sync2 & agree);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/zx_ula_port.sv
// ZX Spectrum ULA I/O port block.
//   clk, reset (async, active-low)
//   ce, rd_n, wr_n, ad[15:0], data_in[7:0] : Z80 I/O bus (active-low strobes)
//   data_out[7:0], data_oe                 : read data and bus-mux drive request
//   int_n                                  : frame interrupt, active low
//   keys_n[39:0], ear_in                   : raw key matrix and tape input
//   border[2:0], mic, speaker              : latched output port bits
//   frame_tick                             : one-cycle pulse on the last frame cycle
// Any even port address selects the ULA. Reads are combinational from registered
// state; writes latch on the first cycle of a low wr_n.
module zx_ula_port import zx_pkg::*; #(
  parameter int CLK_HZ     = 3_500_000,
  parameter int FRAME_HZ   = 50,
  parameter int INT_CYCLES = 32,
  parameter int DB_CYCLES  = 35_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic [15:0]         ad,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic                int_n,
  input  logic [KEY_NUM-1:0]  keys_n,
  input  logic                ear_in,
  output logic [2:0]          border,
  output logic                mic,
  output logic                speaker,
  output logic                frame_tick
);

  localparam int PERIOD = CLK_HZ / FRAME_HZ;
  localparam int FCW    = $clog2(PERIOD);
  localparam int PCW    = $clog2(INT_CYCLES + 1);

  logic               sel;
  logic               wr_q;
  logic               strobe;
  logic               ear_s1;
  logic               ear_sync;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_COLS-1:0] row_and;
  logic [FCW-1:0]     frame_cnt;
  logic [PCW-1:0]     pulse_cnt;
  logic               unused_bits;

  // A1..A7 and data bits 7:5 have no function on this port
  assign unused_bits = ^{ad[7:1], data_in[7:5]};

  assign sel     = !ce && !ad[0];
  assign data_oe = sel && !rd_n;
  assign strobe  = sel && !wr_n && wr_q;

  zx_key_debounce #(
    .WIDTH     (KEY_NUM),
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (keys_n),
    .state (key_state)
  );

  // each low address line A8..A15 enables one half-row; selected rows are ANDed
  always_comb begin
    row_and = '1;
    for (int r = 0; r < KEY_ROWS; r++) begin
      if (!ad[8+r]) row_and = row_and & key_state[r*KEY_COLS +: KEY_COLS];
    end
    data_out = 8'hFF;
    if (data_oe) begin
      data_out[KEY_COLS-1:0]   = row_and;
      data_out[ULA_EAR_BIT]    = ear_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q     <= 1'b1;
      border   <= '0;
      mic      <= 1'b0;
      speaker  <= 1'b0;
      ear_s1   <= 1'b1;
      ear_sync <= 1'b1;
    end else begin
      wr_q     <= wr_n;
      ear_s1   <= ear_in;
      ear_sync <= ear_s1;
      if (strobe) begin
        border  <= data_in[2:0];
        mic     <= data_in[ULA_MIC_BIT];
        speaker <= data_in[ULA_SPK_BIT];
      end
    end
  end

  assign frame_tick = (frame_cnt == FCW'(PERIOD - 1));

  // int_n falls on the edge that wraps the frame counter and is held low
  // for INT_CYCLES cycles by a separate pulse counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      pulse_cnt <= '0;
      int_n     <= 1'b1;
    end else begin
      if (frame_tick) begin
        frame_cnt <= '0;
        pulse_cnt <= '0;
        int_n     <= 1'b0;
      end else begin
        frame_cnt <= frame_cnt + FCW'(1);
        if (!int_n) begin
          if (pulse_cnt == PCW'(INT_CYCLES - 1)) int_n <= 1'b1;
          else pulse_cnt <= pulse_cnt + PCW'(1);
        end
      end
    end
  end

endmodule
